// File: rtl/rejestry_odczyt.sv
// rejestry_odczyt: fetches two operands through one register-file read port, forwarding same-cycle writes
module rejestry_odczyt #(
  parameter int Rx_liczba = 8,
  parameter int DATA_W = 8,
  localparam int NR_W = $clog2(Rx_liczba)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [NR_W-1:0]   req_nr_a,
  input  logic [NR_W-1:0]   req_nr_b,
  output logic [NR_W-1:0]   rd_nr,
  input  logic [DATA_W-1:0] rd_dane,
  input  logic              wr_Rx,
  input  logic [NR_W-1:0]   nr_Rx,
  input  logic [DATA_W-1:0] dane,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b
);
  typedef enum logic [1:0] {IDLE, READ_A, READ_B, DONE} state_t;
  state_t state, state_n;
  logic [NR_W-1:0] nr_a, nr_b;
  logic [DATA_W-1:0] rd_val;
  // a write landing on the address being read wins over the stale array value
  assign rd_val = (wr_Rx && nr_Rx == rd_nr) ? dane : rd_dane;
  always_comb begin
    req_ready = rst && state == IDLE;
    op_valid = state == DONE;
    rd_nr = state == READ_A ? nr_a : state == IDLE ? '0 : nr_b;
    state_n = state == IDLE ? (req_valid && req_ready ? READ_A : IDLE) :
              state == READ_A ? READ_B :
              state == READ_B ? DONE :
              op_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      nr_a <= '0;
      nr_b <= '0;
      op_a <= '0;
      op_b <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        nr_a <= req_nr_a;
        nr_b <= req_nr_b;
      end
      if (state == READ_A) op_a <= rd_val;
      if (state == READ_B) op_b <= rd_val;
    end
  end
endmodule

// File: tb/tb_rejestry_odczyt.sv
// tb_rejestry_odczyt: directed vector table plus randomized run against a transaction-level model
module tb_rejestry_odczyt;
  logic clk = 0, rst = 0, req_valid = 0, req_ready, wr_Rx = 0, op_valid, op_ready = 0;
  logic [2:0] req_nr_a = 0, req_nr_b = 0, rd_nr, nr_Rx = 0;
  logic [7:0] rd_dane, dane = 0, op_a, op_b;
  logic [7:0] regs [8];
  int checks = 0, failures = 0;
  int age = 0;
  logic [2:0] ma = 0, mb = 0;
  logic [7:0] ea = 0, eb = 0;

  typedef struct {
    logic rs, rv;
    logic [2:0] a, b;
    logic w;
    logic [2:0] wn;
    logic [7:0] wd;
    logic ordy, e_rr, e_ov;
    logic [2:0] e_rd;
    logic [7:0] e_a, e_b;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;
  assign rd_dane = regs[rd_nr];

  rejestry_odczyt #(.Rx_liczba(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_nr_a(req_nr_a), .req_nr_b(req_nr_b), .rd_nr(rd_nr), .rd_dane(rd_dane),
    .wr_Rx(wr_Rx), .nr_Rx(nr_Rx), .dane(dane), .op_valid(op_valid),
    .op_ready(op_ready), .op_a(op_a), .op_b(op_b)
  );

  function automatic vec_t v(logic rs, logic rv, logic [2:0] a, logic [2:0] b, logic w,
                             logic [2:0] wn, logic [7:0] wd, logic ordy, logic rr, logic ov,
                             logic [2:0] rd, logic [7:0] xa, logic [7:0] xb);
    vec_t t;
    t.rs = rs; t.rv = rv; t.a = a; t.b = b; t.w = w; t.wn = wn; t.wd = wd; t.ordy = ordy;
    t.e_rr = rr; t.e_ov = ov; t.e_rd = rd; t.e_a = xa; t.e_b = xb;
    return t;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // value a register holds as of the current cycle, including a write landing now
  function automatic logic [7:0] seen(logic [2:0] n);
    return (wr_Rx && nr_Rx == n) ? dane : regs[n];
  endfunction

  task automatic step();
    int n_age = age;
    logic [2:0] n_ma = ma, n_mb = mb;
    logic [7:0] n_ea = ea, n_eb = eb;
    if (!rst) begin
      n_age = 0; n_ma = 0; n_mb = 0; n_ea = 0; n_eb = 0;
    end else if (age == 0) begin
      if (req_valid) begin n_age = 1; n_ma = req_nr_a; n_mb = req_nr_b; end
    end else if (age == 1) begin
      n_ea = seen(ma); n_age = 2;
    end else if (age == 2) begin
      n_eb = seen(mb); n_age = 3;
    end else if (op_ready) n_age = 0;
    @(posedge clk);
    #1;
    if (wr_Rx) regs[nr_Rx] = dane;
    age = n_age; ma = n_ma; mb = n_mb; ea = n_ea; eb = n_eb;
    @(negedge clk);
    chk("model_req_ready", {7'b0, req_ready}, {7'b0, rst && age == 0});
    chk("model_op_valid", {7'b0, op_valid}, {7'b0, age >= 3});
    chk("model_rd_nr", {5'b0, rd_nr}, {5'b0, age == 1 ? ma : age >= 2 ? mb : 3'd0});
    chk("model_op_a", op_a, ea);
    chk("model_op_b", op_b, eb);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 8'(i * 17);
    regs[1] = 8'h7E; regs[2] = 8'h33; regs[3] = 8'hF0; regs[5] = 8'h0F;
    tbl.push_back(v(0,0,0,0,0,0,8'h00,0, 0,0,0,8'h00,8'h00));
    tbl.push_back(v(0,1,3,5,0,0,8'h00,0, 0,0,0,8'h00,8'h00));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,0, 1,0,0,8'h00,8'h00));
    tbl.push_back(v(1,1,3,5,0,0,8'h00,0, 0,0,3,8'h00,8'h00));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,0, 0,0,5,8'hF0,8'h00));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,0, 0,1,5,8'hF0,8'h0F));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,1, 1,0,0,8'hF0,8'h0F));
    tbl.push_back(v(1,1,3,5,0,0,8'h00,0, 0,0,3,8'hF0,8'h0F));
    tbl.push_back(v(1,0,0,0,1,3,8'hAA,0, 0,0,5,8'hAA,8'h0F));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,0, 0,1,5,8'hAA,8'h0F));
    tbl.push_back(v(1,0,0,0,1,3,8'hF0,1, 1,0,0,8'hAA,8'h0F));
    tbl.push_back(v(1,1,3,5,0,0,8'h00,0, 0,0,3,8'hAA,8'h0F));
    tbl.push_back(v(1,0,0,0,1,4,8'h55,0, 0,0,5,8'hF0,8'h0F));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,0, 0,1,5,8'hF0,8'h0F));
    tbl.push_back(v(1,1,3,5,1,3,8'h11,0, 0,1,5,8'hF0,8'h0F));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1,1,3,5,0,0,8'h00,0, 0,1,5,8'hF0,8'h0F));
    tbl.push_back(v(1,1,3,5,0,0,8'h00,1, 1,0,0,8'hF0,8'h0F));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,0, 1,0,0,8'hF0,8'h0F));
    tbl.push_back(v(1,1,2,2,0,0,8'h00,0, 0,0,2,8'hF0,8'h0F));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,0, 0,0,2,8'h33,8'h0F));
    tbl.push_back(v(1,0,0,0,1,2,8'h44,0, 0,1,2,8'h33,8'h44));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,1, 1,0,0,8'h33,8'h44));
    tbl.push_back(v(1,1,3,5,0,0,8'h00,0, 0,0,3,8'h33,8'h44));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,0, 0,0,5,8'h11,8'h44));
    tbl.push_back(v(0,0,0,0,0,0,8'h00,0, 0,0,0,8'h00,8'h00));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,0, 1,0,0,8'h00,8'h00));
    tbl.push_back(v(1,1,1,1,0,0,8'h00,0, 0,0,1,8'h00,8'h00));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,0, 0,0,1,8'h7E,8'h00));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,0, 0,1,1,8'h7E,8'h7E));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,1, 1,0,0,8'h7E,8'h7E));
    foreach (tbl[i]) begin
      rst = tbl[i].rs; req_valid = tbl[i].rv; req_nr_a = tbl[i].a; req_nr_b = tbl[i].b;
      wr_Rx = tbl[i].w; nr_Rx = tbl[i].wn; dane = tbl[i].wd; op_ready = tbl[i].ordy;
      step();
      chk($sformatf("v%0d_req_ready", i), {7'b0, req_ready}, {7'b0, tbl[i].e_rr});
      chk($sformatf("v%0d_op_valid", i), {7'b0, op_valid}, {7'b0, tbl[i].e_ov});
      chk($sformatf("v%0d_rd_nr", i), {5'b0, rd_nr}, {5'b0, tbl[i].e_rd});
      chk($sformatf("v%0d_op_a", i), op_a, tbl[i].e_a);
      chk($sformatf("v%0d_op_b", i), op_b, tbl[i].e_b);
    end
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 49) != 0;
      req_valid = 1'($urandom_range(0, 1));
      req_nr_a = 3'($urandom);
      req_nr_b = 3'($urandom);
      wr_Rx = $urandom_range(0, 9) < 3;
      nr_Rx = 3'($urandom);
      dane = 8'($urandom);
      op_ready = $urandom_range(0, 9) < 4;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rejestry_odczyt.md
Name: rejestry_odczyt

Overview:
Operand-fetch unit on the read side of the `Rejestry` register file. It accepts a request carrying two register numbers over a valid/ready handshake. It reads both registers sequentially through a single read port and returns the operand pair to the ALU/decoder over a second valid/ready handshake. It snoops the register-file write port so a write landing in the same cycle as a read is forwarded.

Parameters:
Rx_liczba, 8, number of registers; must be a power of two, >= 2
DATA_W, 8, register data width
(NR_W = $clog2(Rx_liczba), derived localparam)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
req_valid  in  1  operand request present
req_ready  out  1  unit can accept a request
req_nr_a  in  NR_W  register number of operand A
req_nr_b  in  NR_W  register number of operand B
rd_nr  out  NR_W  read address to register file
rd_dane  in  DATA_W  register file combinational read data for rd_nr (same cycle)
wr_Rx  in  1  snooped register-file write enable
nr_Rx  in  NR_W  snooped write address
dane  in  DATA_W  snooped write data
op_valid  out  1  operand pair valid
op_ready  in  1  consumer accepts operand pair
op_a  out  DATA_W  operand A
op_b  out  DATA_W  operand B

Behaviour:
- FSM states: IDLE, READ_A, READ_B, DONE.
- Reset (rst==0 at edge): state=IDLE; op_a=0, op_b=0; latched numbers=0; op_valid=0.
- req_ready is forced to 0 while rst==0.
- Requests presented during reset are ignored.
- IDLE: req_ready=1, rd_nr=0, op_valid=0. When req_valid&&req_ready at an edge: latch req_nr_a and req_nr_b, go to READ_A.
- READ_A: rd_nr=nr_a, req_ready=0. At the edge, capture op_a and go to READ_B.
  - Captured value = dane if (wr_Rx && nr_Rx==nr_a), else rd_dane.
- READ_B: rd_nr=nr_b. At the edge, capture op_b with the same forwarding rule against nr_b, then go to DONE.
  - Forwarding also covers the case nr_a==nr_b with a write in READ_B only. In that case op_a keeps the old value and op_b gets the new value; this is intentional (reads are point-in-time).
- DONE: op_valid=1, req_ready=0, rd_nr=nr_b.
  - op_a/op_b are frozen snapshots; writes after capture do not change them.
  - When op_ready=1 at an edge: go to IDLE, so op_valid drops the next cycle.
  - While op_ready=0: hold indefinitely; op_a, op_b and op_valid stay stable.
- Latency: request accepted at edge E0 → op_valid high from E2 to the first edge with op_ready=1.
  - Minimum request-to-request spacing is 4 cycles; no back-to-back acceptance from DONE.
- op_a, op_b and the latched numbers are registers. req_ready, op_valid and rd_nr are decoded from state (and rst for req_ready).
- rst==0 mid-operation (any state): abort at that edge, return to the reset values above, and discard the pending operands.
- Out-of-range numbers cannot occur (NR_W exact). Values passed unmodified, full DATA_W width, no arithmetic.

Test Plan:
1. Reset: hold rst=0 for 2 cycles → op_valid=0, op_a=op_b=0, req_ready=0. Release → req_ready=1 next cycle.
2. Basic fetch: regfile model R3=0xF0, R5=0x0F; request (a=3, b=5) accepted at E0.
   - rd_nr=3 during cycle 1, rd_nr=5 during cycle 2.
   - op_valid=1 after E2, op_a=0xF0, op_b=0x0F.
   - With op_ready=1: returns to IDLE, req_ready=1 one cycle later.
3. Forwarding: R3=0xF0; during READ_A drive wr_Rx=1, nr_Rx=3, dane=0xAA → op_a=0xAA.
   - Repeat with nr_Rx=4 → op_a=0xF0 (no false forward).
4. Backpressure: op_ready=0 for 5 cycles in DONE, with a write R3=0x11 meanwhile.
   - op_valid, op_a=0xF0 and op_b stay stable; req_ready=0 with req_valid=1 held, and no acceptance.
   - Raise op_ready → exactly one transfer.
5. Same register: a=b=2, R2=0x33; write R2=0x44 during READ_B → op_a=0x33, op_b=0x44.
6. Mid-operation reset: rst=0 at the READ_B edge → next cycle state IDLE-reset, op_valid=0, op_a=0. After release, a new request (a=1, b=1, R1=0x7E) → op_a=op_b=0x7E.
